// File: rtl/tcdm_bank_pkg.sv
// rtl/tcdm_bank_pkg.sv - shared types and helpers for the TCDM bank responder
//
// Purpose: bank state encoding and the per-byte parity helper used when
//          parity protection is compiled in (TCDM_BANK_PARITY_EN).
// Ports:   none (package).

package tcdm_bank_pkg;

  typedef enum logic [0:0] {
    BANK_INIT  = 1'b0,
    BANK_READY = 1'b1
  } bank_state_e;

  // Even parity: the stored bit makes the 9-bit group have an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/tcdm_bank_responder_if.sv
// rtl/tcdm_bank_responder_if.sv - interconnect-to-bank request/response bundle
//
// Purpose: groups the TCDM bank-side handshake and data signals.
// Modports:
//   master - interconnect side: drives req/add/wen/wdata/be/stall, sees gnt/rdata/status
//   slave  - bank side (tcdm_bank_responder)
// Signals: req_i, gnt_o, add_i[AddrMemWidth], wen_i, wdata_i[DataWidth], be_i[BeWidth],
//          rdata_o[DataWidth], stall_i, init_done_o, par_err_o (suffixes are bank-relative).

interface tcdm_bank_responder_if #(
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8
);

  logic                    req_i;
  logic                    gnt_o;
  logic [AddrMemWidth-1:0] add_i;
  logic                    wen_i;
  logic [DataWidth-1:0]    wdata_i;
  logic [BeWidth-1:0]      be_i;
  logic [DataWidth-1:0]    rdata_o;
  logic                    stall_i;
  logic                    init_done_o;
  logic                    par_err_o;

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i, stall_i,
    input  gnt_o, rdata_o, init_done_o, par_err_o
  );

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i, stall_i,
    output gnt_o, rdata_o, init_done_o, par_err_o
  );

endinterface

// File: rtl/tcdm_bank_resp_pipe.sv
// rtl/tcdm_bank_resp_pipe.sv - Depth-stage load-response delay line
//
// Purpose: delays load data plus its parity-error flag by Depth cycles. Each
//          stage only captures when its source is valid, so the last stage
//          holds the most recent result until the next one arrives.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high clear
//   valid_i            a load was accepted this cycle
//   data_i, err_i      data read at the accept edge and its parity-error flag
//   valid_o            one-cycle pulse when a new result reaches data_o
//   data_o             held result
//   err_o              parity error, asserted only alongside valid_o

module tcdm_bank_resp_pipe #(
  parameter int unsigned Depth     = 1,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 err_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 err_o
);

  logic [Depth-1:0]     valid_q;
  logic [Depth-1:0]     err_q;
  logic [DataWidth-1:0] data_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int k = 0; k < int'(Depth); k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) begin
        data_q[0] <= data_i;
        err_q[0]  <= err_i;
      end
      for (int k = 1; k < int'(Depth); k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) begin
          data_q[k] <= data_q[k-1];
          err_q[k]  <= err_q[k-1];
        end
      end
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign data_o  = data_q[Depth-1];
  // err_q is held like the data, so gate it to make the flag a single pulse.
  assign err_o   = valid_q[Depth-1] & err_q[Depth-1];

endmodule

// File: rtl/tcdm_bank_responder.sv
// rtl/tcdm_bank_responder.sv - TCDM bank-side responder with init sweep
//
// Purpose: single-port word-addressed bank behind the TCDM interconnect.
//          Grants combinationally once the post-reset zero sweep is done,
//          applies byte-enabled stores at the accept edge and returns load
//          data exactly RespLat cycles after the grant.
// Optional feature macro: TCDM_BANK_PARITY_EN (per-byte even parity, par_err_o
//          pulse, flip_bit(addr, bit_idx) hook). Without it par_err_o is 0.
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-high reset (array contents are not reset)
//   bus     tcdm_bank_responder_if.slave: req/gnt/add/wen/wdata/be/rdata,
//           stall_i, init_done_o, par_err_o

module tcdm_bank_responder
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned RespLat      = 1,
  parameter bit          InitOnReset  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  tcdm_bank_responder_if.slave   bus
);

  localparam int unsigned NumWords = 2 ** AddrMemWidth;
  localparam logic [AddrMemWidth-1:0] LastAddr = '1;
  localparam bank_state_e ResetState = InitOnReset ? BANK_INIT : BANK_READY;

  if (RespLat == 0 || NumWords < 2) begin : g_bad_cfg
    $fatal(1, "tcdm_bank_responder: RespLat must be >= 1 and NumWords >= 2");
  end
  if (BeWidth * 8 != DataWidth) begin : g_bad_be
    $fatal(1, "tcdm_bank_responder: BeWidth must equal DataWidth/8");
  end

  bank_state_e             state_q;
  logic [AddrMemWidth-1:0] init_cnt_q;
  logic                    init_done_q;

  logic [DataWidth-1:0]    mem_q [NumWords];

  logic                    gnt;
  logic                    accept;
  logic [DataWidth-1:0]    rd_data;
  logic                    rd_err;
  logic                    pipe_valid;
  logic                    pipe_err;
  logic [DataWidth-1:0]    pipe_data;

  // Sweep FSM: one zero-write per cycle, READY after the last word is written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ResetState;
      init_cnt_q  <= '0;
      init_done_q <= !InitOnReset;
    end else begin
      case (state_q)
        BANK_INIT: begin
          init_cnt_q <= init_cnt_q + AddrMemWidth'(1);
          if (init_cnt_q == LastAddr) begin
            state_q     <= BANK_READY;
            init_done_q <= 1'b1;
          end
        end
        BANK_READY: ;
        default: state_q <= ResetState;
      endcase
    end
  end

  assign gnt    = bus.req_i & (state_q == BANK_READY) & ~bus.stall_i;
  assign accept = bus.req_i & gnt;

  // Asynchronous read: the value seen at the accept edge predates any store
  // landing on that same edge, which gives read-before-write ordering.
  assign rd_data = mem_q[bus.add_i];

`ifdef TCDM_BANK_PARITY_EN
  logic [BeWidth-1:0] par_q [NumWords];
  logic [BeWidth-1:0] rd_par_calc;

  always_comb begin
    rd_par_calc = '0;
    for (int b = 0; b < int'(BeWidth); b++) begin
      rd_par_calc[b] = byte_parity(rd_data[8*b +: 8]);
    end
  end

  assign rd_err = |(rd_par_calc ^ par_q[bus.add_i]);

  always_ff @(posedge clk_i) begin
    if (state_q == BANK_INIT) begin
      par_q[init_cnt_q] <= '0;
    end else if (accept && bus.wen_i) begin
      for (int b = 0; b < int'(BeWidth); b++) begin
        if (bus.be_i[b]) begin
          par_q[bus.add_i][b] <= byte_parity(bus.wdata_i[8*b +: 8]);
        end
      end
    end
  end

  // Corrupts one stored data bit without touching its parity.
  task automatic flip_bit(input int unsigned addr, input int unsigned bit_idx);
    mem_q[addr[AddrMemWidth-1:0]][bit_idx] = ~mem_q[addr[AddrMemWidth-1:0]][bit_idx];
  endtask
`else
  assign rd_err = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (state_q == BANK_INIT) begin
      mem_q[init_cnt_q] <= '0;
    end else if (accept && bus.wen_i) begin
      for (int b = 0; b < int'(BeWidth); b++) begin
        if (bus.be_i[b]) begin
          mem_q[bus.add_i][8*b +: 8] <= bus.wdata_i[8*b +: 8];
        end
      end
    end
  end

  tcdm_bank_resp_pipe #(
    .Depth     (RespLat),
    .DataWidth (DataWidth)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (accept & ~bus.wen_i),
    .data_i  (rd_data),
    .err_i   (rd_err),
    .valid_o (pipe_valid),
    .data_o  (pipe_data),
    .err_o   (pipe_err)
  );

  assign bus.gnt_o       = gnt;
  assign bus.rdata_o     = pipe_data;
  assign bus.init_done_o = init_done_q;

`ifdef TCDM_BANK_PARITY_EN
  logic unused_pipe_valid;
  assign unused_pipe_valid = pipe_valid;
  assign bus.par_err_o     = pipe_err;
`else
  logic [1:0] unused_pipe;
  assign unused_pipe   = {pipe_valid, pipe_err};
  assign bus.par_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// tb/tb_tcdm_bank_responder.sv - scoreboard bench for tcdm_bank_responder

module tb_tcdm_bank_responder;

  localparam int AW       = 4;
  localparam int NWORDS   = 16;
  localparam int RESP_LAT = 2;

  typedef struct {
    logic [31:0] data;
    int          due;
    logic        perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tcdm_bank_responder_if #(.AddrMemWidth(AW), .DataWidth(32), .BeWidth(4)) bus ();

  tcdm_bank_responder #(
    .AddrMemWidth (AW),
    .DataWidth    (32),
    .BeWidth      (4),
    .RespLat      (RESP_LAT),
    .InitOnReset  (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  logic [31:0] model_mem [NWORDS];
  logic [3:0]  model_bad [NWORDS];
  exp_t        sb_q [$];
  logic [31:0] exp_rdata = '0;
  int          ecount = 0;
  int          rel_ecount = 0;
  bit          in_reset = 1'b1;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) ecount++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, ecount, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NWORDS; i++) begin
      model_mem[i] = '0;
      model_bad[i] = '0;
    end
  endtask

  // Monitor: every cycle the bank's output must equal the last result due.
  always @(negedge clk) begin : monitor
    logic exp_perr;
    exp_perr = 1'b0;
    if (sb_q.size() > 0 && sb_q[0].due == ecount) begin
      exp_rdata = sb_q[0].data;
      exp_perr  = sb_q[0].perr;
      void'(sb_q.pop_front());
    end
    check("rdata", bus.rdata_o, exp_rdata);
    check("par_err", {31'b0, bus.par_err_o}, {31'b0, exp_perr});
  end

  task automatic drive(input logic req, input logic wen, input logic [3:0] add,
                       input logic [31:0] wdata, input logic [3:0] be, input logic stall);
    logic ready;
    logic exp_gnt;
    exp_t e;
    @(negedge clk);
    bus.req_i   = req;
    bus.wen_i   = wen;
    bus.add_i   = add;
    bus.wdata_i = wdata;
    bus.be_i    = be;
    bus.stall_i = stall;
    #1;
    ready   = !in_reset && (ecount - rel_ecount >= NWORDS);
    exp_gnt = req & ready & ~stall;
    check("gnt", {31'b0, bus.gnt_o}, {31'b0, exp_gnt});
    check("init_done", {31'b0, bus.init_done_o}, {31'b0, ready});
    if (exp_gnt) begin
      if (wen) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            model_mem[add][8*b +: 8] = wdata[8*b +: 8];
            model_bad[add][b] = 1'b0;
          end
        end
      end else begin
        e.data = model_mem[add];
        e.due  = ecount + RESP_LAT;
        e.perr = |model_bad[add];
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic store(input logic [3:0] add, input logic [31:0] wdata, input logic [3:0] be);
    drive(1'b1, 1'b1, add, wdata, be, 1'b0);
  endtask

  task automatic load(input logic [3:0] add);
    drive(1'b1, 1'b0, add, $urandom, 4'hF, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst = 1'b1;
    in_reset = 1'b1;
    sb_q.delete();
    exp_rdata = '0;
    bus.req_i = 1'b0;
    repeat (hold) @(negedge clk);
    #2;
    rst = 1'b0;
    in_reset = 1'b0;
    rel_ecount = ecount;
    model_clear();
  endtask

  initial begin
    bus.req_i = 1'b0; bus.wen_i = 1'b0; bus.add_i = '0;
    bus.wdata_i = '0; bus.be_i = '0; bus.stall_i = 1'b0;
    model_clear();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    in_reset = 1'b0;
    rel_ecount = ecount;

    // Sweep: request held throughout, first grant exactly NWORDS cycles in.
    repeat (NWORDS + 2) load(4'd5);

    // Byte-enabled merge
    store(4'd3, 32'hDEADBEEF, 4'b1111);
    store(4'd3, 32'h000000AA, 4'b0001);
    load(4'd3);
    store(4'd4, 32'h12345678, 4'b0000);
    load(4'd4);

    // Stall blocks the grant; releasing it grants the same cycle
    repeat (5) drive(1'b1, 1'b1, 4'd3, 32'hFFFFFFFF, 4'hF, 1'b1);
    repeat (5) drive(1'b1, 1'b0, 4'd3, 32'h0, 4'hF, 1'b1);
    load(4'd3);

    // Back-to-back loads with an interleaved store
    store(4'd1, 32'h11, 4'hF);
    store(4'd2, 32'h22, 4'hF);
    store(4'd3, 32'h33, 4'hF);
    load(4'd1);
    load(4'd2);
    store(4'd2, 32'h99, 4'hF);
    load(4'd3);
    load(4'd2);
    repeat (RESP_LAT + 1) idle();

    // Reset one cycle after a load grant: the result must never appear
    store(4'd9, 32'hCAFEF00D, 4'hF);
    load(4'd9);
    do_reset(2);
    repeat (NWORDS + 1) load(4'd9);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
            4'($urandom_range(0, NWORDS - 1)), $urandom,
            4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 2));
    end

`ifdef TCDM_BANK_PARITY_EN
    store(4'd7, 32'h01020304, 4'hF);
    store(4'd6, 32'h0A0B0C0D, 4'hF);
    idle();
    dut.flip_bit(7, 9);
    model_mem[7][9] = ~model_mem[7][9];
    model_bad[7][1] = 1'b1;
    load(4'd7);
    load(4'd6);
    repeat (RESP_LAT + 1) idle();
`endif

    repeat (RESP_LAT + 2) idle();
    check("drain", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
